// File: rtl/multiplicador_secuencial.sv
// Time-multiplexed matrix multiplier C = A x B using P MAC lanes, one inner-product step per cycle.
// Optional macro MULT_ACC_EN adds the 'acc' input so a run can add A x B onto the previous result.
module multiplicador_secuencial #(
   parameter int Bit   = 3,
   parameter int log2M = 2,
   parameter int EBit  = 2*Bit+log2M,
   parameter int M     = 4,
   parameter int N     = 2,
   parameter int P     = 2,
   parameter int SIGNO = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
`ifdef MULT_ACC_EN
   input  logic                  acc,
`endif
   input  logic [N*M*Bit-1:0]    in1w,
   input  logic [M*P*Bit-1:0]    in2w,
   output logic                  busy,
   output logic                  done,
   output logic [P*N*EBit-1:0]   out
);

   // state    | meaning
   // ST_IDLE  | waiting for start; operands captured on the start edge
   // ST_RUN   | one MAC step per cycle over rows i and inner index k
   // ST_DONE  | single cycle with done high and out holding the new result
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int KW = (M > 1) ? $clog2(M) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(N-1);
   localparam logic [KW-1:0] K_LAST = KW'(M-1);

   state_t state_q, state_d;
   logic [N*M*Bit-1:0]  a_q;
   logic [M*P*Bit-1:0]  b_q;
   logic [IW-1:0]       i_q;
   logic [KW-1:0]       k_q;
   logic [EBit-1:0]     acc_q [P];
   logic [P*N*EBit-1:0] res_q;
   logic                acc_mode_q;

   logic                load;
   logic                last_k;
   logic                last_row;
   logic [Bit-1:0]      a_sel;
   logic [EBit-1:0]     a_ext;
   logic [EBit-1:0]     b_ext;
   logic [EBit-1:0]     pre;
   logic [EBit-1:0]     sum [P];
   logic [P*N*EBit-1:0] res_d;

   function automatic logic [EBit-1:0] ext(input logic [Bit-1:0] x);
      if (SIGNO != 0) return {{(EBit-Bit){x[Bit-1]}}, x};
      else            return {{(EBit-Bit){1'b0}}, x};
   endfunction

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      last_k   = (k_q == K_LAST);
      last_row = last_k && (i_q == I_LAST);
      case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_RUN;
            load    = 1'b1;
         end
         ST_RUN:  if (last_row) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q == ST_RUN);

   // Lane j adds A[i][k]*B[k][j]; the completed row is spliced into a copy of the buffer so
   // the last row can reach out on the same edge that enters ST_DONE.
   always_comb begin
      a_sel = a_q[(int'(i_q)*M + int'(k_q))*Bit +: Bit];
      a_ext = ext(a_sel);
      res_d = res_q;
      for (int j = 0; j < P; j++) begin
         b_ext = ext(b_q[(int'(k_q)*P + j)*Bit +: Bit]);
         pre   = '0;
`ifdef MULT_ACC_EN
         if (acc_mode_q && (k_q == '0))
            pre = out[int'(i_q)*P*EBit + j*EBit +: EBit];
`endif
         sum[j] = acc_q[j] + (a_ext * b_ext) + pre;
         res_d[int'(i_q)*P*EBit + j*EBit +: EBit] = sum[j];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         i_q        <= '0;
         k_q        <= '0;
         res_q      <= '0;
         out        <= '0;
         done       <= 1'b0;
         acc_mode_q <= 1'b0;
         for (int j = 0; j < P; j++) acc_q[j] <= '0;
      end else begin
         state_q <= state_d;
         done    <= 1'b0;
         if (load) begin
            a_q <= in1w;
            b_q <= in2w;
            i_q <= '0;
            k_q <= '0;
`ifdef MULT_ACC_EN
            acc_mode_q <= acc;
`else
            acc_mode_q <= 1'b0;
`endif
            for (int j = 0; j < P; j++) acc_q[j] <= '0;
         end else if (state_q == ST_RUN) begin
            if (last_k) begin
               res_q <= res_d;
               k_q   <= '0;
               i_q   <= last_row ? '0 : i_q + 1'b1;
               for (int j = 0; j < P; j++) acc_q[j] <= '0;
               if (last_row) begin
                  out  <= res_d;
                  done <= 1'b1;
               end
            end else begin
               k_q <= k_q + 1'b1;
               for (int j = 0; j < P; j++) acc_q[j] <= sum[j];
            end
         end
      end
   end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Bench for multiplicador_secuencial: unsigned and signed instances share stimulus and are
// checked against hand-computed matrices, latency, start masking, reset and back-to-back runs.
module tb_multiplicador_secuencial;
   localparam int Bit = 3, log2M = 2, EBit = 2*Bit+log2M, M = 4, N = 2, P = 2;
   localparam int AW = N*M*Bit, BW = M*P*Bit, CW = P*N*EBit;

   logic clk = 1'b0;
   logic rst, start, acc_en;
   logic [AW-1:0] in1w;
   logic [BW-1:0] in2w;
   logic busy_u, done_u, busy_s, done_s;
   logic [CW-1:0] out_u, out_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multiplicador_secuencial #(.Bit(Bit), .log2M(log2M), .M(M), .N(N), .P(P), .SIGNO(0)) dut_u (
      .clk(clk), .rst(rst), .start(start),
`ifdef MULT_ACC_EN
      .acc(acc_en),
`endif
      .in1w(in1w), .in2w(in2w), .busy(busy_u), .done(done_u), .out(out_u));

   multiplicador_secuencial #(.Bit(Bit), .log2M(log2M), .M(M), .N(N), .P(P), .SIGNO(1)) dut_s (
      .clk(clk), .rst(rst), .start(start),
`ifdef MULT_ACC_EN
      .acc(acc_en),
`endif
      .in1w(in1w), .in2w(in2w), .busy(busy_s), .done(done_s), .out(out_s));

   typedef struct {
      logic [AW-1:0] a;
      logic [BW-1:0] b;
      logic [CW-1:0] cu;
      logic [CW-1:0] cs;
      string         nm;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Start edge at the end of cycle 0; busy expected in cycles 1..8, done and new out in cycle 9.
   task automatic run_check(input logic [AW-1:0] a, input logic [BW-1:0] b,
                            input logic [CW-1:0] cu, input logic [CW-1:0] cs,
                            input logic accv, input string nm);
      int nb = 0;
      int early = 0;
      @(negedge clk);
      in1w = a; in2w = b; start = 1'b1; acc_en = accv;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start = 1'b0; acc_en = 1'b0;
            in1w = AW'($urandom); in2w = BW'($urandom);
         end
         if (busy_u && busy_s) nb++;
         if (done_u || done_s) early++;
      end
      chk({nm, " busy_cycles"}, 64'(nb), 64'd8);
      chk({nm, " early_done"}, 64'(early), 64'd0);
      @(negedge clk);
      chk({nm, " done_c9"}, {62'd0, done_u, done_s}, 64'd3);
      chk({nm, " busy_c9"}, {62'd0, busy_u, busy_s}, 64'd0);
      chk({nm, " out_u"}, 64'(out_u), 64'(cu));
      chk({nm, " out_s"}, 64'(out_s), 64'(cs));
      @(negedge clk);
      chk({nm, " done_c10"}, {62'd0, done_u, done_s}, 64'd0);
      chk({nm, " hold_u"}, 64'(out_u), 64'(cu));
   endtask

   initial begin
      int ndone;
      int first_dc;
      int second_dc;

      vecs[0] = '{a: {8{3'd7}}, b: {8{3'd7}}, cu: {4{8'hC4}}, cs: {4{8'h04}}, nm: "all7"};
      vecs[1] = '{a: {3'd0,3'd7,3'd6,3'd5, 3'd4,3'd3,3'd2,3'd1},
                  b: {3'd0,3'd0, 3'd0,3'd0, 3'd1,3'd0, 3'd0,3'd1},
                  cu: {8'd6,8'd5,8'd2,8'd1}, cs: {8'hFE,8'hFD,8'd2,8'd1}, nm: "ident"};
      vecs[2] = '{a: {8{3'd4}}, b: {8{3'd3}}, cu: {4{8'h30}}, cs: {4{8'hD0}}, nm: "m4x3"};
      vecs[3] = '{a: {8{3'd4}}, b: {8{3'd4}}, cu: {4{8'h40}}, cs: {4{8'h40}}, nm: "m4x4"};
      vecs[4] = '{a: {3'd2,3'd0,3'd0,3'd0, 3'd0,3'd0,3'd0,3'd1},
                  b: {3'd7,3'd5, 3'd0,3'd0, 3'd0,3'd0, 3'd1,3'd3},
                  cu: {8'd14,8'd10,8'd1,8'd3}, cs: {8'hFE,8'hFA,8'd1,8'd3}, nm: "mixed"};

      rst = 1'b1; start = 1'b0; acc_en = 1'b0; in1w = '0; in2w = '0;
      repeat (2) @(negedge clk);
      chk("reset busy", {62'd0, busy_u, busy_s}, 64'd0);
      chk("reset done", {62'd0, done_u, done_s}, 64'd0);
      chk("reset out_u", 64'(out_u), 64'd0);
      chk("reset out_s", 64'(out_s), 64'd0);
      rst = 1'b0;

      for (int v = 0; v < 5; v++)
         run_check(vecs[v].a, vecs[v].b, vecs[v].cu, vecs[v].cs, 1'b0, vecs[v].nm);

      // Extra start pulses in cycles 3 (RUN) and 9 (DONE) must not launch or restart a run.
      @(negedge clk);
      in1w = vecs[0].a; in2w = vecs[0].b; start = 1'b1;
      ndone = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = (c == 3 || c == 9);
         if (c == 3) begin in1w = vecs[2].a; in2w = vecs[2].b; end
         if (done_u) ndone++;
      end
      chk("ignore done_count", 64'(ndone), 64'd1);
      chk("ignore out_u", 64'(out_u), 64'(vecs[0].cu));
      chk("ignore out_s", 64'(out_s), 64'(vecs[0].cs));
      chk("ignore busy", {62'd0, busy_u, busy_s}, 64'd0);

      // Reset in cycle 5 of a run clears everything immediately.
      @(negedge clk);
      in1w = vecs[2].a; in2w = vecs[2].b; start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      chk("midrst busy", {62'd0, busy_u, busy_s}, 64'd0);
      chk("midrst done", {62'd0, done_u, done_s}, 64'd0);
      chk("midrst out_u", 64'(out_u), 64'd0);
      chk("midrst out_s", 64'(out_s), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_check(vecs[1].a, vecs[1].b, vecs[1].cu, vecs[1].cs, 1'b0, "after_rst");

      // start held high: runs separated by one IDLE cycle, so done lands in cycles 9 and 19.
      @(negedge clk);
      in1w = vecs[3].a; in2w = vecs[3].b; start = 1'b1;
      ndone = 0; first_dc = -1; second_dc = -1;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (done_u) begin
            ndone++;
            if (first_dc < 0) first_dc = c;
            else if (second_dc < 0) second_dc = c;
         end
      end
      start = 1'b0;
      chk("b2b first_done", 64'(first_dc), 64'd9);
      chk("b2b second_done", 64'(second_dc), 64'd19);
      chk("b2b count", 64'(ndone), 64'd2);
      chk("b2b out_s", 64'(out_s), 64'(vecs[3].cs));
      repeat (12) @(negedge clk);

`ifdef MULT_ACC_EN
      run_check(vecs[0].a, vecs[0].b, {4{8'hC4}}, {4{8'h04}}, 1'b0, "acc0");
      run_check(vecs[0].a, vecs[0].b, {4{8'h88}}, {4{8'h08}}, 1'b1, "acc1");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
